// File: rtl/nios_system_timer_driver.sv
// ---------------------------------------------------------------------------
// nios_system_timer_driver
//
// Avalon-MM master that owns a point-to-point link to the interval timer's
// s1 port. It programs period and control, services every timeout by
// clearing the status register (one tick per timeout), can stop the timer,
// and can take a counter snapshot and read both halves back.
//
// Timer register map (16-bit registers):
//   0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h
//
// Ports:
//   clk, reset_n          system clock (posedge), async active-low reset
//   cfg_start             one-cycle request to (re)program and start
//   cfg_period            raw load value (interval = cfg_period + 1 clocks)
//   cfg_continuous        1 = periodic, 0 = one-shot
//   stop_req              one-cycle request to stop the timer
//   snap_req              one-cycle request for a counter snapshot
//   avm_address           timer register address           (registered)
//   avm_chipselect        timer select                     (registered)
//   avm_write_n           active-low write strobe          (registered)
//   avm_writedata         write data                       (registered)
//   avm_readdata          timer read data, valid one cycle after address
//   irq                   timer interrupt (level)
//   busy                  high whenever the FSM is not in IDLE
//   tick_pulse            one-cycle pulse per serviced timeout
//   tick_count            serviced-timeout count, wraps at 2^TICK_W
//   snapshot              last snapshot {snap_h, snap_l}
//   snapshot_valid        one-cycle pulse when snapshot updates
// ---------------------------------------------------------------------------
module nios_system_timer_driver #(
    parameter int unsigned TICK_W         = 32,
    parameter bit          CLEAR_ON_START = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              stop_req,
    input  logic              snap_req,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              irq,
    output logic              busy,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snapshot,
    output logic              snapshot_valid
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        WR_CTRL,
        RUN,
        CLR_ST,
        STOP_WR,
        SNAP_WR,
        SNAP_RL,
        SNAP_RH,
        SNAP_CAP
    } state_t;

    localparam logic [2:0] A_STATUS   = 3'd0;
    localparam logic [2:0] A_CONTROL  = 3'd1;
    localparam logic [2:0] A_PERIOD_L = 3'd2;
    localparam logic [2:0] A_PERIOD_H = 3'd3;
    localparam logic [2:0] A_SNAP_L   = 3'd4;
    localparam logic [2:0] A_SNAP_H   = 3'd5;

    state_t             state_q, state_d;
    logic [31:0]        period_q, period_d;
    logic               cont_q, cont_d;
    logic               deaf_q, deaf_d;
    logic [15:0]        snap_lo_q, snap_lo_d;
    logic [2:0]         addr_q, addr_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               busy_q, busy_d;
    logic               tick_pulse_q, tick_pulse_d;
    logic [TICK_W-1:0]  tick_count_q, tick_count_d;
    logic [31:0]        snapshot_q, snapshot_d;
    logic               snapshot_valid_q, snapshot_valid_d;

    always_comb begin
        state_d          = state_q;
        period_d         = period_q;
        cont_d           = cont_q;
        deaf_d           = 1'b0;
        snap_lo_d        = snap_lo_q;
        tick_pulse_d     = 1'b0;
        tick_count_d     = tick_count_q;
        snapshot_d       = snapshot_q;
        snapshot_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d  = WR_PL;
                    period_d = cfg_period;
                    cont_d   = cfg_continuous;
                    if (CLEAR_ON_START) tick_count_d = '0;
                end
            end
            WR_PL:   state_d = WR_PH;
            WR_PH:   state_d = WR_CTRL;
            WR_CTRL: state_d = RUN;
            RUN: begin
                // Fixed priority, one request per cycle; losers are dropped.
                // The deaf cycle only masks irq, which the timer still holds
                // high for one cycle after the status clear.
                if (irq && !deaf_q) begin
                    state_d = CLR_ST;
                end else if (cfg_start) begin
                    state_d  = WR_PL;
                    period_d = cfg_period;
                    cont_d   = cfg_continuous;
                    if (CLEAR_ON_START) tick_count_d = '0;
                end else if (stop_req) begin
                    state_d = STOP_WR;
                end else if (snap_req) begin
                    state_d = SNAP_WR;
                end
            end
            CLR_ST: begin
                tick_pulse_d = 1'b1;
                tick_count_d = tick_count_q + TICK_W'(1);
                if (cont_q) begin
                    state_d = RUN;
                    deaf_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            STOP_WR: state_d = IDLE;
            SNAP_WR: state_d = SNAP_RL;
            SNAP_RL: state_d = SNAP_RH;
            SNAP_RH: begin
                // Read data for the snap_l read issued in SNAP_RL.
                snap_lo_d = avm_readdata;
                state_d   = SNAP_CAP;
            end
            SNAP_CAP: begin
                // Read data for the snap_h read issued in SNAP_RH.
                snapshot_d       = {avm_readdata, snap_lo_q};
                snapshot_valid_d = 1'b1;
                state_d          = RUN;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered, so they are decoded from the state
        // being entered: the bus cycle lines up with the state that owns it.
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = '0;
        wdata_d = '0;
        unique case (state_d)
            WR_PL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PERIOD_L;
                wdata_d = period_d[15:0];
            end
            WR_PH: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_PERIOD_H;
                wdata_d = period_d[31:16];
            end
            WR_CTRL: begin
                // {STOP, START, CONT, ITO}
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CONTROL;
                wdata_d = {12'h000, 1'b0, 1'b1, cont_d, 1'b1};
            end
            CLR_ST: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_STATUS;
            end
            STOP_WR: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_CONTROL;
                wdata_d = 16'h0008;
            end
            SNAP_WR: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = A_SNAP_L;
            end
            SNAP_RL: begin
                cs_d = 1'b1; addr_d = A_SNAP_L;
            end
            SNAP_RH: begin
                cs_d = 1'b1; addr_d = A_SNAP_H;
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            period_q         <= '0;
            cont_q           <= 1'b0;
            deaf_q           <= 1'b0;
            snap_lo_q        <= '0;
            addr_q           <= '0;
            cs_q             <= 1'b0;
            wn_q             <= 1'b1;
            wdata_q          <= '0;
            busy_q           <= 1'b0;
            tick_pulse_q     <= 1'b0;
            tick_count_q     <= '0;
            snapshot_q       <= '0;
            snapshot_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            period_q         <= period_d;
            cont_q           <= cont_d;
            deaf_q           <= deaf_d;
            snap_lo_q        <= snap_lo_d;
            addr_q           <= addr_d;
            cs_q             <= cs_d;
            wn_q             <= wn_d;
            wdata_q          <= wdata_d;
            busy_q           <= busy_d;
            tick_pulse_q     <= tick_pulse_d;
            tick_count_q     <= tick_count_d;
            snapshot_q       <= snapshot_d;
            snapshot_valid_q <= snapshot_valid_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wdata_q;
    assign busy           = busy_q;
    assign tick_pulse     = tick_pulse_q;
    assign tick_count     = tick_count_q;
    assign snapshot       = snapshot_q;
    assign snapshot_valid = snapshot_valid_q;

endmodule

// File: tb/tb_nios_system_timer_driver.sv
// ---------------------------------------------------------------------------
// Bench for nios_system_timer_driver. Two instances share all stimulus and
// the timer model: one with TICK_W=32, one with TICK_W=4 (wrap check).
// A transaction-level model predicts every output each cycle; directed
// scenarios add literal expectations for the documented cases.
// ---------------------------------------------------------------------------
module tb_nios_system_timer_driver;

    localparam logic [31:0] SNAP_VAL = 32'hABCD_1234;
    localparam logic [1:0]  E_NONE = 2'd0, E_TICK = 2'd1, E_STOP = 2'd2, E_SNAP = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        cfg_continuous = 1'b0;
    logic        stop_req = 1'b0;
    logic        snap_req = 1'b0;
    logic [15:0] avm_readdata = '0;
    logic        irq = 1'b0;
    logic        irq_set = 1'b0;
    logic        clr_pend = 1'b0;

    logic [2:0]  a_addr;  logic a_cs; logic a_wn; logic [15:0] a_wdata;
    logic        a_busy;  logic a_tp; logic [31:0] a_cnt; logic [31:0] a_snap; logic a_sv;
    logic [2:0]  b_addr;  logic b_cs; logic b_wn; logic [15:0] b_wdata;
    logic        b_busy;  logic b_tp; logic [3:0] b_cnt;  logic [31:0] b_snap; logic b_sv;

    always #5 clk = ~clk;

    nios_system_timer_driver #(.TICK_W(32), .CLEAR_ON_START(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req),
        .avm_address(a_addr), .avm_chipselect(a_cs), .avm_write_n(a_wn),
        .avm_writedata(a_wdata), .avm_readdata(avm_readdata), .irq(irq),
        .busy(a_busy), .tick_pulse(a_tp), .tick_count(a_cnt),
        .snapshot(a_snap), .snapshot_valid(a_sv)
    );

    nios_system_timer_driver #(.TICK_W(4), .CLEAR_ON_START(1'b1)) dut4 (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req),
        .avm_address(b_addr), .avm_chipselect(b_cs), .avm_write_n(b_wn),
        .avm_writedata(b_wdata), .avm_readdata(avm_readdata), .irq(irq),
        .busy(b_busy), .tick_pulse(b_tp), .tick_count(b_cnt),
        .snapshot(b_snap), .snapshot_valid(b_sv)
    );

    // Timer slave model: irq is a registered level that drops one cycle after
    // the status write; reads return registered data one cycle later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq          <= 1'b0;
            clr_pend     <= 1'b0;
            avm_readdata <= '0;
        end else begin
            clr_pend <= a_cs && !a_wn && (a_addr == 3'd0);
            if (irq_set)       irq <= 1'b1;
            else if (clr_pend) irq <= 1'b0;
            if (a_cs && a_wn)
                avm_readdata <= (a_addr == 3'd4) ? SNAP_VAL[15:0] :
                                (a_addr == 3'd5) ? SNAP_VAL[31:16] : 16'h0000;
            else
                avm_readdata <= 16'h0000;
        end
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot = n_tot + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct packed {
        logic        cs;
        logic        wn;
        logic [2:0]  a;
        logic [15:0] d;
        logic [1:0]  eff;
    } beat_t;

    function automatic beat_t mk(input logic cs, input logic wn, input logic [2:0] a,
                                 input logic [15:0] d, input logic [1:0] eff);
        beat_t b;
        b.cs = cs; b.wn = wn; b.a = a; b.d = d; b.eff = eff;
        return b;
    endfunction

    beat_t       m_q[$];
    beat_t       m_cur = '0;
    logic        m_free = 1'b1;
    logic        m_run = 1'b0;
    logic        m_cont = 1'b0;
    logic        m_deaf = 1'b0;
    logic [31:0] m_cnt = '0;
    logic [31:0] m_snap = '0;
    logic        m_tp = 1'b0;
    logic        m_sv = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_q.delete();
                m_free = 1'b1; m_run = 1'b0; m_cont = 1'b0; m_deaf = 1'b0;
                m_cnt = '0; m_snap = '0; m_tp = 1'b0; m_sv = 1'b0;
            end else begin
                m_tp = 1'b0;
                m_sv = 1'b0;
                if (m_free) begin
                    if (m_run && irq && !m_deaf) begin
                        m_q.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, E_TICK));
                    end else if (cfg_start) begin
                        m_run  = 1'b1;
                        m_cont = cfg_continuous;
                        m_cnt  = '0;
                        m_q.push_back(mk(1'b1, 1'b0, 3'd2, cfg_period[15:0], E_NONE));
                        m_q.push_back(mk(1'b1, 1'b0, 3'd3, cfg_period[31:16], E_NONE));
                        m_q.push_back(mk(1'b1, 1'b0, 3'd1,
                                         cfg_continuous ? 16'h0007 : 16'h0005, E_NONE));
                    end else if (m_run && stop_req) begin
                        m_q.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0008, E_STOP));
                    end else if (m_run && snap_req) begin
                        m_q.push_back(mk(1'b1, 1'b0, 3'd4, 16'h0000, E_NONE));
                        m_q.push_back(mk(1'b1, 1'b1, 3'd4, 16'h0000, E_NONE));
                        m_q.push_back(mk(1'b1, 1'b1, 3'd5, 16'h0000, E_NONE));
                        m_q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0000, E_SNAP));
                    end
                    m_deaf = 1'b0;
                end else begin
                    case (m_cur.eff)
                        E_TICK: begin
                            m_cnt = m_cnt + 32'd1;
                            m_tp  = 1'b1;
                            if (m_cont) m_deaf = 1'b1;
                            else        m_run  = 1'b0;
                        end
                        E_STOP: m_run = 1'b0;
                        E_SNAP: begin
                            m_snap = SNAP_VAL;
                            m_sv   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (m_q.size() != 0) begin
                    m_cur  = m_q.pop_front();
                    m_free = 1'b0;
                end else begin
                    m_free = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare + bus logging ----------------
    logic [18:0] wlog[$];
    logic [2:0]  rlog[$];
    int          tp_cyc = 0;
    int          sv_cyc = 0;
    int          sv_n = 0;

    initial begin
        logic [20:0] exp_bus;
        logic        exp_busy;
        forever begin
            @(negedge clk);
            exp_bus  = m_free ? {1'b0, 1'b1, 3'd0, 16'h0000}
                              : {m_cur.cs, m_cur.wn, m_cur.a, m_cur.d};
            exp_busy = !m_free || m_run;
            chk("bus",            {43'd0, a_cs, a_wn, a_addr, a_wdata}, {43'd0, exp_bus});
            chk("busy",           {63'd0, a_busy}, {63'd0, exp_busy});
            chk("tick_pulse",     {63'd0, a_tp},   {63'd0, m_tp});
            chk("tick_count",     {32'd0, a_cnt},  {32'd0, m_cnt});
            chk("snapshot",       {32'd0, a_snap}, {32'd0, m_snap});
            chk("snapshot_valid", {63'd0, a_sv},   {63'd0, m_sv});
            chk("w4_tick_count",  {60'd0, b_cnt},  {60'd0, m_cnt[3:0]});
            chk("w4_others", {23'd0, b_cs, b_wn, b_addr, b_wdata, b_busy, b_tp, b_sv},
                             {23'd0, exp_bus, exp_busy, m_tp, m_sv});
            if (a_cs && !a_wn) wlog.push_back({a_addr, a_wdata});
            if (a_cs && a_wn)  rlog.push_back(a_addr);
            if (a_tp) tp_cyc = cyc_n;
            if (a_sv) begin sv_n = sv_n + 1; sv_cyc = cyc_n; end
        end
    end

    function automatic logic [18:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return '1;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // irq becomes high in the cycle that is current when this returns (t).
    task automatic raise_irq(output int t);
        irq_set = 1'b1;
        @(negedge clk);
        irq_set = 1'b0;
        t = cyc_n;
    endtask

    task automatic start(input logic [31:0] per, input logic cont);
        cfg_period     = per;
        cfg_continuous = cont;
        cfg_start      = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        int rq;

        // Reset values
        cycles(3);
        chk("rst_bus", {43'd0, a_cs, a_wn, a_addr, a_wdata}, {43'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
        chk("rst_busy_cnt", {31'd0, a_busy, a_cnt}, 64'd0);
        reset_n = 1'b1;
        cycles(2);

        // Program continuous, period 0x0001_2345
        wlog.delete();
        start(32'h0001_2345, 1'b1);
        cycles(4);
        chk("prog_nwrites", wlog.size(), 3);
        chk("prog_w0", wl(0), {3'd2, 16'h2345});
        chk("prog_w1", wl(1), {3'd3, 16'h0001});
        chk("prog_w2", wl(2), {3'd1, 16'h0007});
        chk("prog_busy", a_busy, 1);

        // Three timeouts; timer holds irq through the deaf cycle
        for (int i = 0; i < 3; i++) begin
            wlog.delete();
            raise_irq(t);
            cycles(5);
            chk("irq_tick_latency", tp_cyc - t, 2);
            chk("irq_status_write", wl(0), {3'd0, 16'h0000});
        end
        chk("three_ticks", a_cnt, 3);

        // Snapshot: valid pulse lands the cycle after SNAP_CAP
        wlog.delete(); rlog.delete(); sv_n = 0;
        snap_req = 1'b1;
        rq = cyc_n;
        @(negedge clk);
        snap_req = 1'b0;
        cycles(7);
        chk("snap_value", a_snap, 32'hABCD_1234);
        chk("snap_valid_once", sv_n, 1);
        chk("snap_valid_cycle", sv_cyc - rq, 5);
        chk("snap_write", {45'd0, wlog.size() == 1, wl(0)}, {45'd0, 1'b1, 3'd4, 16'h0000});
        chk("snap_reads", {rlog.size() == 2, (rlog.size() == 2) ? {rlog[0], rlog[1]} : 6'h3f},
                          {1'b1, 3'd4, 3'd5});

        // irq + stop + snap together: only the status clear happens
        wlog.delete(); rlog.delete(); sv_n = 0;
        irq_set = 1'b1;
        @(negedge clk);
        irq_set  = 1'b0;
        stop_req = 1'b1;
        snap_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        snap_req = 1'b0;
        cycles(5);
        chk("prio_nwrites", wlog.size(), 1);
        chk("prio_status", wl(0), {3'd0, 16'h0000});
        chk("prio_no_reads", rlog.size(), 0);
        chk("prio_still_busy", a_busy, 1);
        chk("prio_count", a_cnt, 4);

        // stop alone
        wlog.delete();
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        cycles(3);
        chk("stop_write", {45'd0, wlog.size() == 1, wl(0)}, {45'd0, 1'b1, 3'd1, 16'h0008});
        chk("stop_idle", a_busy, 0);

        // One-shot, period 9
        wlog.delete();
        start(32'd9, 1'b0);
        cycles(4);
        chk("os_w0", wl(0), {3'd2, 16'h0009});
        chk("os_w1", wl(1), {3'd3, 16'h0000});
        chk("os_ctrl", wl(2), {3'd1, 16'h0005});
        chk("os_cleared", a_cnt, 0);
        raise_irq(t);
        cycles(5);
        chk("os_one_tick", a_cnt, 1);
        chk("os_idle", a_busy, 0);
        wlog.delete();
        raise_irq(t);
        cycles(5);
        chk("os_ignored_cnt", a_cnt, 1);
        chk("os_ignored_bus", wlog.size(), 0);

        // Reset asserted mid-programming (WR_PH)
        start(32'h0000_0100, 1'b1);
        @(negedge clk);
        chk("in_wr_ph", {a_cs, a_wn, a_addr, a_wdata}, {1'b1, 1'b0, 3'd3, 16'h0000});
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_bus", {a_cs, a_wn, a_addr, a_wdata}, {1'b0, 1'b1, 3'd0, 16'h0000});
        chk("async_flags", {a_busy, a_tp, a_sv, b_busy}, 4'b0000);
        chk("async_cnt", {a_cnt, 28'd0, b_cnt}, 64'd0);
        chk("async_snap", a_snap, 32'd0);
        cycles(2);
        reset_n = 1'b1;
        cycles(2);

        // 16 ticks: 4-bit counter wraps to 0
        start(32'd3, 1'b1);
        cycles(4);
        for (int i = 0; i < 16; i++) begin
            raise_irq(t);
            cycles(4);
        end
        chk("wrap_w4", b_cnt, 0);
        chk("wrap_w32", a_cnt, 16);

        cycles(3);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
